// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and sizing helper for piso_serializer.
// PARITY is reachable only in builds that define PISO_PARITY_EN.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, framed serial-out shift register.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_first,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] sreg;
  logic [DATA_WIDTH-1:0] sreg_shf;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;
  logic                  at_last;
  logic                  head;
  logic                  emit_v;
  logic                  emit_d;
  logic                  emit_f;
  logic                  emit_l;
`ifdef PISO_PARITY_EN
  logic                  par;
`endif

  assign at_last = (state == SHIFT) && (cnt == CNT_LAST);
  assign accept  = din_valid && din_ready;
  assign busy    = (state != IDLE);

  assign head = MSB_FIRST ? sreg[DATA_WIDTH-1] : sreg[0];
  assign sreg_shf = MSB_FIRST ? {sreg[DATA_WIDTH-2:0], 1'b0}
                              : {1'b0, sreg[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (at_last) begin
`ifdef PISO_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = accept ? SHIFT : IDLE;
`endif
        end
      end
      PARITY: begin
        state_nxt = accept ? SHIFT : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Ready is a function of state/counter only, never of din_valid.
  always_comb begin
    din_ready = 1'b0;
    emit_v    = 1'b0;
    emit_d    = 1'b0;
    emit_f    = 1'b0;
    emit_l    = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        din_ready = 1'b1;
      end
      state == SHIFT: begin
        emit_v = 1'b1;
        emit_d = head;
        emit_f = (cnt == '0);
`ifndef PISO_PARITY_EN
        emit_l    = at_last;
        din_ready = at_last;
`endif
      end
`ifdef PISO_PARITY_EN
      state == PARITY: begin
        emit_v    = 1'b1;
        emit_d    = par;
        emit_l    = 1'b1;
        din_ready = 1'b1;
      end
`endif
      default: begin
        din_ready = 1'b0;
      end
    endcase
  end

  // Counter saturates at the last bit; a new accept restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= din;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      sreg <= sreg_shf;
      if (!at_last) cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^din;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      dout       <= emit_d;
      dout_valid <= emit_v;
      dout_first <= emit_f;
      dout_last  <= emit_l;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: MSB-first and LSB-first instances driven in parallel,
// checked cycle by cycle against a frame-schedule reference model.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready_m, dout_m, dout_valid_m, dout_first_m, dout_last_m, busy_m;
  logic         din_ready_l, dout_l, dout_valid_l, dout_first_l, dout_last_l, busy_l;
  logic [9:0]   obs;

  int n_cmp = 0;
  int n_bad = 0;

  bit ev[256];
  bit ebm[256];
  bit ebl[256];
  bit ef[256];
  bit el[256];
  bit eb[256];
  int free_at;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_m), .dout(dout_m), .dout_valid(dout_valid_m),
    .dout_first(dout_first_m), .dout_last(dout_last_m), .busy(busy_m)
  );

  piso_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_l), .dout(dout_l), .dout_valid(dout_valid_l),
    .dout_first(dout_first_l), .dout_last(dout_last_l), .busy(busy_l)
  );

  assign obs = {dout_valid_m, dout_m, dout_first_m, dout_last_m, busy_m,
                dout_valid_l, dout_l, dout_first_l, dout_last_l, busy_l};

  task automatic clear_model();
    for (int e = 0; e < 256; e++) begin
      ev[e] = 0; ebm[e] = 0; ebl[e] = 0; ef[e] = 0; el[e] = 0; eb[e] = 0;
    end
    free_at = 0;
  endtask

  // Word accepted at edge a: busy after edges a..a+FL-1, bits after a+1..a+FL.
  task automatic plan(input logic [W-1:0] w, input int a);
    for (int k = 0; k < FL; k++) begin
      ev[a+1+k]  = 1;
      ef[a+1+k]  = (k == 0);
      el[a+1+k]  = (k == FL - 1);
      ebm[a+1+k] = (k < W) ? w[W-1-k] : ^w;
      ebl[a+1+k] = (k < W) ? w[k] : ^w;
      eb[a+k]    = 1;
    end
    free_at = a + FL;
  endtask

  function automatic logic [9:0] exp_at(input int e);
    return {ev[e], ebm[e], ef[e], el[e], eb[e],
            ev[e], ebl[e], ef[e], el[e], eb[e]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    din = '0;
    @(negedge clk);
    n_cmp++;
    if (obs !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want %b", obs, 10'b0);
    end
    n_cmp++;
    if ({din_ready_m, din_ready_l} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 11", {din_ready_m, din_ready_l});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 10'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b want %b", obs, 10'b0);
    end
  endtask

  task automatic test_frame(input logic [W-1:0] w);
    clear_model();
    for (int c = 0; c < FL + 3; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (obs !== exp_at(c-1)) begin
          n_bad++;
          $display("FAIL frame_%h c=%0d: got %b want %b", w, c, obs, exp_at(c-1));
        end
      end
      n_cmp++;
      if ({din_ready_m, din_ready_l} !== {2{c >= free_at}}) begin
        n_bad++;
        $display("FAIL frame_%h_ready c=%0d: got %b want %b", w, c,
                 {din_ready_m, din_ready_l}, {2{c >= free_at}});
      end
      din_valid = (c == 0);
      din = (c == 0) ? w : W'($urandom);
      if (din_valid && c >= free_at) plan(w, c);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    clear_model();
    for (int c = 0; c < 2 * FL + 3; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (obs !== exp_at(c-1)) begin
          n_bad++;
          $display("FAIL b2b c=%0d: got %b want %b", c, obs, exp_at(c-1));
        end
      end
      n_cmp++;
      if ({din_ready_m, din_ready_l} !== {2{c >= free_at}}) begin
        n_bad++;
        $display("FAIL b2b_ready c=%0d: got %b want %b", c,
                 {din_ready_m, din_ready_l}, {2{c >= free_at}});
      end
      w = (c == 0) ? 8'hFF : 8'h00;
      din_valid = (c <= FL);
      din = w;
      if (din_valid && c >= free_at) plan(w, c);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_ignore_busy();
    logic [W-1:0] w;
    clear_model();
    w = W'($urandom);
    for (int c = 0; c < FL + 3; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (obs !== exp_at(c-1)) begin
          n_bad++;
          $display("FAIL ignore c=%0d: got %b want %b", c, obs, exp_at(c-1));
        end
      end
      n_cmp++;
      if ({din_ready_m, din_ready_l} !== {2{c >= free_at}}) begin
        n_bad++;
        $display("FAIL ignore_ready c=%0d: got %b want %b", c,
                 {din_ready_m, din_ready_l}, {2{c >= free_at}});
      end
      din_valid = (c == 0) || (c >= 2 && c < FL - 1 && c[0]);
      din = (c == 0) ? w : W'($urandom);
      if (din_valid && c >= free_at) plan(w, c);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    clear_model();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (obs !== exp_at(c-1)) begin
          n_bad++;
          $display("FAIL midrst c=%0d: got %b want %b", c, obs, exp_at(c-1));
        end
      end
      din_valid = (c == 0);
      din = 8'hC3;
      if (din_valid && c >= free_at) plan(8'hC3, c);
    end
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 10'b0 || {din_ready_m, din_ready_l} !== 2'b11) begin
      n_bad++;
      $display("FAIL midrst_async: got %b/%b want %b/11", obs,
               {din_ready_m, din_ready_l}, 10'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 10'b0) begin
      n_bad++;
      $display("FAIL midrst_idle: got %b want %b", obs, 10'b0);
    end
    test_frame(8'h3C);
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    clear_model();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (obs !== exp_at(c-1)) begin
          n_bad++;
          $display("FAIL random c=%0d: got %b want %b", c, obs, exp_at(c-1));
        end
      end
      n_cmp++;
      if ({din_ready_m, din_ready_l} !== {2{c >= free_at}}) begin
        n_bad++;
        $display("FAIL random_ready c=%0d: got %b want %b", c,
                 {din_ready_m, din_ready_l}, {2{c >= free_at}});
      end
      w = W'($urandom);
      din_valid = (c < 180) && ($urandom_range(0, 3) != 0);
      din = w;
      if (din_valid && c >= free_at) plan(w, c);
    end
    din_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h01);
    test_frame(8'h07);
    test_frame(8'h03);
    for (int i = 0; i < 4; i++) test_frame(W'($urandom));
    test_back_to_back();
    test_ignore_busy();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
